// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte-stream requesters.
// A grant stays locked to one requester until it sends a byte flagged last, so packets are never interleaved.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [PTR_W-1:0]     grant_id
);

    typedef enum logic [1:0] {
        S_ARB,
        S_SEND,
        S_WAIT
    } state_t;

    state_t           state;
    logic             lock;
    logic [PTR_W-1:0] rr;

    logic             found;
    logic [PTR_W-1:0] g;
    logic [N_REQ-1:0] g_onehot;
    logic [7:0]       g_data;
    logic             g_last;
    logic [PTR_W-1:0] rr_next;

    // Rotating search: indices at or above rr come first, then the wrapped ones below rr.
    always_comb begin
        found = 1'b0;
        g     = '0;
        if (lock) begin
            g = grant_id;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (PTR_W'(i) == grant_id && req_valid[i]) begin
                    found = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] && PTR_W'(i) >= rr) begin
                    found = 1'b1;
                    g     = PTR_W'(i);
                end
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] && PTR_W'(i) < rr) begin
                    found = 1'b1;
                    g     = PTR_W'(i);
                end
            end
        end
    end

    always_comb begin
        g_onehot = '0;
        g_data   = '0;
        g_last   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == g) begin
                g_onehot[i] = 1'b1;
                g_data      = req_data[8*i +: 8];
                g_last      = req_last[i];
            end
        end
        rr_next = (g == PTR_W'(N_REQ - 1)) ? '0 : g + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_ARB;
            lock     <= 1'b0;
            rr       <= '0;
            req_ack  <= '0;
            tx_data  <= '0;
            tx_send  <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                S_ARB: begin
                    // tx_ready low means uart_tx is still draining; never start a send then.
                    if (tx_ready && found) begin
                        tx_data  <= g_data;
                        tx_send  <= 1'b1;
                        req_ack  <= g_onehot;
                        grant_id <= g;
                        busy     <= 1'b1;
                        state    <= S_SEND;
                        if (g_last) begin
                            lock <= 1'b0;
                            rr   <= rr_next;
                        end else begin
                            lock <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (!tx_ready) begin
                        tx_send <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_ready) begin
                        state <= S_ARB;
                        busy  <= lock;
                    end
                end
                default: begin
                    state   <= S_ARB;
                    tx_send <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a behavioural uart_tx plus serial decoder feed monitors
// that pop hand-computed expected bytes and grants; a second N_REQ=3 instance covers pointer wrap.
module tb_uart_tx_arbiter;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        urst_n;

    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [1:0]  grant_id;

    logic [2:0]  v3;
    logic [23:0] dat3;
    logic [2:0]  l3;
    logic [2:0]  ack3;
    logic [7:0]  txd3;
    logic        send3;
    logic        ready3 = 1'b1;
    logic        busy3;
    logic [1:0]  gid3;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_bytes [$];
    logic [9:0] exp_ack [$];
    logic [9:0] exp3 [$];

    logic [7:0] rq_data [4][16];
    logic       rq_last [4][16];
    int         rq_len [4];
    int         rq_pos [4];
    logic [3:0] hold;

    int viol = 0;
    int bad3 = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .PTR_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    uart_tx_arbiter #(.N_REQ(3), .PTR_W(2)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (v3),
        .req_data  (dat3),
        .req_last  (l3),
        .req_ack   (ack3),
        .tx_data   (txd3),
        .tx_send   (send3),
        .tx_ready  (ready3),
        .busy      (busy3),
        .grant_id  (gid3)
    );

    // Behavioural uart_tx: 8N1, CPB clocks per bit; has its own reset so it keeps draining across arbiter resets.
    logic       line = 1'b1;
    logic [9:0] u_sh = '1;
    int         u_bit = 0;
    int         u_cnt = 0;

    always @(posedge clk) begin
        if (!urst_n) begin
            tx_ready <= 1'b1;
            line     <= 1'b1;
            u_bit    <= 0;
            u_cnt    <= 0;
        end else if (tx_ready) begin
            if (tx_send) begin
                u_sh     <= {1'b1, tx_data, 1'b0};
                tx_ready <= 1'b0;
                line     <= 1'b0;
                u_bit    <= 0;
                u_cnt    <= 0;
            end
        end else if (u_cnt == CPB - 1) begin
            u_cnt <= 0;
            if (u_bit == 9) begin
                tx_ready <= 1'b1;
                line     <= 1'b1;
            end else begin
                u_bit <= u_bit + 1;
                line  <= u_sh[u_bit + 1];
            end
        end else begin
            u_cnt <= u_cnt + 1;
        end
    end

    // Minimal handshake model for the 3-requester instance.
    int cnt3 = 0;
    always @(posedge clk) begin
        if (ready3) begin
            if (send3) begin
                ready3 <= 1'b0;
                cnt3   <= 6;
            end
        end else if (cnt3 == 0) begin
            ready3 <= 1'b1;
        end else begin
            cnt3 <= cnt3 - 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add_byte(input int i, input logic [7:0] b, input logic last);
        rq_data[i][rq_len[i]] = b;
        rq_last[i][rq_len[i]] = last;
        rq_len[i]++;
    endtask

    task automatic expect_tx(input logic [1:0] idx, input logic [7:0] b);
        exp_bytes.push_back(b);
        exp_ack.push_back({idx, b});
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while ((exp_bytes.size() != 0 || exp_ack.size() != 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_outstanding"}, exp_bytes.size() + exp_ack.size(), 0);
    endtask

    task automatic wait3(input string nm);
        int c;
        c = 0;
        while (ack3 == 3'b000 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no ack within 100 cycles, got 0 acks, expected 1", nm);
        end
    endtask

    // Requester driver: a byte stays presented until its ack is seen, then the next one (or valid drops).
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        hold      = '0;
        for (int i = 0; i < 4; i++) begin
            rq_len[i] = 0;
            rq_pos[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i]) rq_pos[i]++;
                req_valid[i] = !hold[i] && (rq_pos[i] < rq_len[i]);
                req_data[8*i +: 8] = req_valid[i] ? rq_data[i][rq_pos[i]] : 8'h00;
                req_last[i]        = req_valid[i] ? rq_last[i][rq_pos[i]] : 1'b0;
            end
        end
    end

    // Serial decoder monitor: samples mid-bit and compares each frame with the next expected byte.
    initial begin
        logic [7:0] rx;
        logic       stop;
        forever begin
            @(negedge line);
            repeat (CPB / 2) @(posedge clk);
            #1;
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(posedge clk);
                #1;
                rx[b] = line;
            end
            repeat (CPB) @(posedge clk);
            #1;
            stop = line;
            if (exp_bytes.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL serial_unexpected: got byte 0x%0h, expected no frame", rx);
            end else begin
                check("serial_frame", {23'b0, stop, rx}, {23'b0, 1'b1, exp_bytes.pop_front()});
            end
        end
    end

    // Grant monitors for both instances, plus protocol and range watchers.
    initial begin
        logic [9:0] e;
        logic       prev_send;
        prev_send = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ack !== 4'b0000) begin
                if (exp_ack.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ack_unexpected: got req_ack 0x%0h, expected none", req_ack);
                end else begin
                    e = exp_ack.pop_front();
                    check("req_ack", {28'b0, req_ack}, 32'(4'b0001 << e[9:8]));
                    check("grant_id", {30'b0, grant_id}, {30'b0, e[9:8]});
                    check("tx_data", {24'b0, tx_data}, {24'b0, e[7:0]});
                end
            end
            if (ack3 !== 3'b000) begin
                if (exp3.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ack3_unexpected: got ack3 0x%0h, expected none", ack3);
                end else begin
                    e = exp3.pop_front();
                    check("ack3", {29'b0, ack3}, 32'(3'b001 << e[9:8]));
                    check("gid3", {30'b0, gid3}, {30'b0, e[9:8]});
                    check("txd3", {24'b0, txd3}, {24'b0, e[7:0]});
                end
            end
            if (tx_send && !prev_send && !tx_ready) viol++;
            prev_send = tx_send;
            if (gid3 >= 2'd3) bad3++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sends;
        int low_busy;
        int c;
        reset_n = 1'b0;
        urst_n  = 1'b0;
        v3 = '0;
        dat3 = '0;
        l3 = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ack", {28'b0, req_ack}, 0);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_tx_send", {31'b0, tx_send}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_grant_id", {30'b0, grant_id}, 0);
        reset_n = 1'b1;
        urst_n  = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte from requester 2.
        add_byte(2, 8'h41, 1'b1);
        expect_tx(2'd2, 8'h41);
        wait_drain("single");

        // All four requesting at once; rr is 3 after the previous grant.
        add_byte(0, 8'h30, 1'b1);
        add_byte(0, 8'h30, 1'b1);
        add_byte(1, 8'h31, 1'b1);
        add_byte(2, 8'h32, 1'b1);
        add_byte(3, 8'h33, 1'b1);
        expect_tx(2'd3, 8'h33);
        expect_tx(2'd0, 8'h30);
        expect_tx(2'd1, 8'h31);
        expect_tx(2'd2, 8'h32);
        expect_tx(2'd0, 8'h30);
        wait_drain("round_robin");

        // Locked 3-byte packet from requester 1 with requester 0 competing.
        add_byte(1, 8'hA0, 1'b0);
        add_byte(1, 8'hA1, 1'b0);
        add_byte(1, 8'hA2, 1'b1);
        add_byte(0, 8'h55, 1'b1);
        add_byte(0, 8'h55, 1'b1);
        expect_tx(2'd1, 8'hA0);
        expect_tx(2'd1, 8'hA1);
        expect_tx(2'd1, 8'hA2);
        expect_tx(2'd0, 8'h55);
        expect_tx(2'd0, 8'h55);
        wait_drain("packet");

        // Locked owner 3 goes quiet after its first byte; requester 0 must stay blocked.
        add_byte(3, 8'hC0, 1'b0);
        add_byte(3, 8'hC1, 1'b1);
        add_byte(0, 8'h55, 1'b1);
        expect_tx(2'd3, 8'hC0);
        expect_tx(2'd3, 8'hC1);
        expect_tx(2'd0, 8'h55);
        c = 0;
        while (c < 200) begin
            @(posedge clk);
            #1;
            c++;
            if (req_ack[3]) break;
        end
        hold[3] = 1'b1;
        repeat (60) @(negedge clk);
        sends = 0;
        low_busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_send) sends++;
            if (!busy) low_busy++;
        end
        check("lock_idle_sends", sends, 0);
        check("lock_idle_busy_low", low_busy, 0);
        hold[3] = 1'b0;
        wait_drain("lock_hold");

        // Reset pulse in the middle of a frame; uart keeps draining on its own.
        add_byte(2, 8'h5A, 1'b1);
        expect_tx(2'd2, 8'h5A);
        c = 0;
        while (!busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        repeat (15) @(negedge clk);
        check("midframe_uart_busy", {31'b0, tx_ready}, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_tx_send", {31'b0, tx_send}, 0);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_req_ack", {28'b0, req_ack}, 0);
        check("midrst_tx_data", {24'b0, tx_data}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        add_byte(1, 8'h77, 1'b1);
        add_byte(3, 8'h78, 1'b1);
        expect_tx(2'd1, 8'h77);
        expect_tx(2'd3, 8'h78);
        wait_drain("after_reset");

        // N_REQ=3: move pointer to 2, then requests on 0 and 2.
        l3 = 3'b111;
        dat3[15:8] = 8'h11;
        v3 = 3'b010;
        exp3.push_back({2'd1, 8'h11});
        wait3("n3_first");
        v3[1] = 1'b0;
        dat3[7:0]   = 8'h20;
        dat3[23:16] = 8'h22;
        v3 = 3'b101;
        exp3.push_back({2'd2, 8'h22});
        exp3.push_back({2'd0, 8'h20});
        @(negedge clk);
        wait3("n3_second");
        v3[2] = 1'b0;
        @(negedge clk);
        wait3("n3_third");
        v3[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("n3_outstanding", exp3.size(), 0);
        check("n3_gid_range", bad3, 0);
        check("send_while_not_ready", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
